// File: rtl/ifu_fetch_reg.sv
// IF stage fetch register: fetch PC, IF/ID instruction latch and an optional fetch counter.
// Define IFU_FETCH_CNT_EN to build the saturating fetched-instruction counter; otherwise fetch_cnt reads 0.
module ifu_fetch_reg #(
  parameter logic [29:0] RESET_PC = 30'h0,
  parameter logic [31:0] NOP_INSN = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] insn,
  input  logic        bus_busy,
  input  logic        stall,
  input  logic        flush,
  input  logic [29:0] new_pc,
  input  logic        br_taken,
  input  logic [29:0] br_addr,
  output logic [29:0] fetch_addr,
  output logic        fetch_as_,
  output logic [29:0] if_pc,
  output logic [31:0] if_insn,
  output logic        if_en,
  output logic [31:0] fetch_cnt
);

  logic [29:0] fetch_pc;
  logic        hold;

  assign hold       = stall | bus_busy;
  assign fetch_addr = fetch_pc;
  assign fetch_as_  = reset;

  // A branch still latches the in-flight word: it is the delay slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      if_pc    <= RESET_PC;
      if_insn  <= NOP_INSN;
      if_en    <= 1'b0;
    end else if (flush) begin
      fetch_pc <= new_pc;
      if_pc    <= new_pc;
      if_insn  <= NOP_INSN;
      if_en    <= 1'b0;
    end else if (!hold) begin
      fetch_pc <= br_taken ? br_addr : fetch_pc + 30'd1;
      if_pc    <= fetch_pc;
      if_insn  <= insn;
      if_en    <= 1'b1;
    end
  end

`ifdef IFU_FETCH_CNT_EN
  logic [31:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (!flush && !hold && cnt != '1) begin
      cnt <= cnt + 32'd1;
    end
  end

  assign fetch_cnt = cnt;
`else
  assign fetch_cnt = '0;
`endif

endmodule

// File: tb/tb_ifu_fetch_reg.sv
// Scoreboard bench for ifu_fetch_reg: a behavioural model predicts each cycle, a monitor compares.
module tb_ifu_fetch_reg;

  localparam logic [29:0] RESET_PC = 30'h0;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, bus_busy, stall, flush, br_taken;
  logic [31:0] insn;
  logic [29:0] new_pc, br_addr;
  logic [29:0] fetch_addr, if_pc;
  logic        fetch_as_, if_en;
  logic [31:0] if_insn, fetch_cnt;

  ifu_fetch_reg #(.RESET_PC(RESET_PC), .NOP_INSN(NOP_INSN)) dut (
    .clk(clk), .reset(reset), .insn(insn), .bus_busy(bus_busy), .stall(stall),
    .flush(flush), .new_pc(new_pc), .br_taken(br_taken), .br_addr(br_addr),
    .fetch_addr(fetch_addr), .fetch_as_(fetch_as_), .if_pc(if_pc),
    .if_insn(if_insn), .if_en(if_en), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] fetch_addr;
    logic [29:0] if_pc;
    logic [31:0] if_insn;
    logic        if_en;
    logic [31:0] fetch_cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  // Behavioural model state (what the IF stage should hold after each edge).
  longint m_pc, m_ipc, m_cnt;
  logic [31:0] m_insn;
  logic        m_en;

  task automatic check(input string name, input longint got, input longint want);
    checks++;
    if (got == want) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, want);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("fetch_addr", longint'(fetch_addr), longint'(e.fetch_addr));
      check("if_pc",      longint'(if_pc),      longint'(e.if_pc));
      check("if_insn",    longint'(if_insn),    longint'(e.if_insn));
      check("if_en",      longint'(if_en),      longint'(e.if_en));
      check("fetch_cnt",  longint'(fetch_cnt),  longint'(e.fetch_cnt));
    end
  end

  // One clock: drive inputs, predict the post-edge state, queue it, advance.
  task automatic cyc(input logic r, input logic fl, input logic st, input logic bb,
                     input logic br, input logic [29:0] ba, input logic [29:0] np,
                     input logic [31:0] word);
    exp_t e;
    reset = r; flush = fl; stall = st; bus_busy = bb;
    br_taken = br; br_addr = ba; new_pc = np; insn = word;
    #1;
    check("fetch_as_", longint'(fetch_as_), r ? 64'd1 : 64'd0);
    if (r) begin
      m_pc = RESET_PC; m_ipc = RESET_PC; m_insn = NOP_INSN; m_en = 1'b0; m_cnt = 0;
    end else if (fl) begin
      m_pc = np; m_ipc = np; m_insn = NOP_INSN; m_en = 1'b0;
    end else if (!(st || bb)) begin
      m_ipc  = m_pc;
      m_insn = word;
      m_en   = 1'b1;
      m_pc   = br ? longint'(ba) : (m_pc + 1) % (64'd1 << 30);
      if (m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
    e.fetch_addr = m_pc[29:0];
    e.if_pc      = m_ipc[29:0];
    e.if_insn    = m_insn;
    e.if_en      = m_en;
`ifdef IFU_FETCH_CNT_EN
    e.fetch_cnt  = m_cnt[31:0];
`else
    e.fetch_cnt  = 32'h0;
`endif
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic seq_n(input int n, input logic [31:0] word);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 30'h0, 30'h0, word);
  endtask

  initial begin
    m_pc = 0; m_ipc = 0; m_insn = '0; m_en = 0; m_cnt = 0;
    // Reset then release with a constant instruction word.
    cyc(1, 0, 0, 0, 0, 30'h0, 30'h0, $urandom);
    cyc(1, 0, 0, 0, 0, 30'h0, 30'h0, $urandom);
    seq_n(4, 32'hA000_0001);
    // Hold for three cycles at 0x10, then release.
    cyc(0, 1, 0, 0, 0, 30'h0, 30'h10, $urandom);
    seq_n(1, $urandom);
    cyc(0, 1, 0, 0, 0, 30'h0, 30'h10, $urandom);
    cyc(0, 0, 1, 0, 0, 30'h0, 30'h0, $urandom);
    cyc(0, 0, 1, 0, 1, 30'h55, 30'h0, $urandom);
    cyc(0, 0, 0, 1, 0, 30'h0, 30'h0, $urandom);
    seq_n(1, $urandom);
    // Branch from 0x20 to 0x100.
    cyc(0, 1, 0, 0, 0, 30'h0, 30'h20, $urandom);
    cyc(0, 0, 0, 0, 1, 30'h100, 30'h0, $urandom);
    seq_n(1, $urandom);
    // Flush beats stall and branch together.
    cyc(0, 1, 1, 1, 1, 30'h200, 30'h40, $urandom);
    seq_n(1, $urandom);
    // PC wrap, then count five fetches after a reset.
    cyc(0, 1, 0, 0, 0, 30'h0, 30'h3FFF_FFFF, $urandom);
    seq_n(2, $urandom);
    cyc(1, 0, 0, 0, 0, 30'h0, 30'h0, $urandom);
    seq_n(5, $urandom);
    // Reset overrides a hold and a branch.
    cyc(0, 0, 1, 0, 0, 30'h0, 30'h0, $urandom);
    cyc(1, 0, 1, 1, 1, 30'h77, 30'h0, $urandom);
    seq_n(2, $urandom);
    cyc(1, 1, 0, 0, 1, 30'h77, 30'h99, $urandom);
    seq_n(2, $urandom);
    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cyc(logic'($urandom_range(0, 49) == 0), logic'($urandom_range(0, 9) == 0),
          logic'($urandom_range(0, 4) == 0), logic'($urandom_range(0, 4) == 0),
          logic'($urandom_range(0, 4) == 0), 30'($urandom), 30'($urandom), $urandom);
    end
    begin
      int budget;
      budget = 0;
      while (q.size() > 0 && budget < 10) begin
        @(posedge clk);
        budget++;
      end
      checks++;
      if (q.size() == 0) passed++;
      else $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ifu_fetch_reg.md
IFU_FETCH_REG -- requirements
Module: ifu_fetch_reg

Interface
REQ-001 The block SHALL use reset reset, synchronous, active-high; clock clk.
REQ-002 The block SHALL have parameter RESET_PC, default 30'h0, the word address loaded into the fetch PC on reset.
REQ-003 The block SHALL have parameter NOP_INSN, default 32'h0, the instruction word presented when the slot is invalid.
REQ-004 The block SHALL have port clk  input  1  clock.
REQ-005 The block SHALL have port reset  input  1  synchronous active-high reset.
REQ-006 The block SHALL have port insn  input  32  instruction word returned by the IFU bus interface for fetch_addr this cycle.
REQ-007 The block SHALL have port bus_busy  input  1  IFU bus interface busy (bus access in progress).
REQ-008 The block SHALL have port stall  input  1  pipeline stall from the controller.
REQ-009 The block SHALL have port flush  input  1  pipeline flush from the controller.
REQ-010 The block SHALL have port new_pc  input  30  redirect word address accompanying flush.
REQ-011 The block SHALL have port br_taken  input  1  branch taken from ID stage.
REQ-012 The block SHALL have port br_addr  input  30  branch target word address.
REQ-013 The block SHALL have port fetch_addr  output  30  word address driven to the IFU bus interface addr.
REQ-014 The block SHALL have port fetch_as_  output  1  active-low fetch strobe to the IFU bus interface.
REQ-015 The block SHALL have port if_pc  output  30  word address of the instruction held in if_insn.
REQ-016 The block SHALL have port if_insn  output  32  registered instruction for ID stage.
REQ-017 The block SHALL have port if_en  output  1  if_insn valid.
REQ-018 The block SHALL have port fetch_cnt  output  32  fetched-instruction count (see Configuration).

Function
REQ-019 Internal register fetch_pc SHALL drive fetch_addr combinationally; fetch_as_ SHALL be 0 whenever reset is 0, and 1 while reset is 1.
REQ-020 Register updates each rising clk SHALL follow strict priority: reset > flush > hold > branch > sequential.
REQ-021 Flush: fetch_pc <= new_pc; if_pc <= new_pc; if_insn <= NOP_INSN; if_en <= 0; insn that cycle is discarded.
REQ-022 Hold (stall==1 or bus_busy==1, flush==0): fetch_pc, if_pc, if_insn, if_en, fetch_cnt all keep their values.
REQ-023 Branch (br_taken==1, no flush/hold): fetch_pc <= br_addr; if_pc <= fetch_pc; if_insn <= insn; if_en <= 1 (the in-flight word is a delay slot, not squashed).
REQ-024 Sequential: fetch_pc <= fetch_pc+1 modulo 2^30 (30'h3FFFFFFF wraps to 30'h0); if_pc <= fetch_pc; if_insn <= insn; if_en <= 1.
REQ-025 br_taken asserted during hold SHALL be ignored; the ID stage holds br_taken/br_addr until hold releases.
REQ-026 Latency: an instruction at fetch_addr in cycle N SHALL appear on if_insn/if_pc in cycle N+1 when not held or flushed.
REQ-027 Flush asserted together with stall, bus_busy or br_taken SHALL take effect as flush.

Reset
REQ-028 On reset: fetch_pc = RESET_PC, if_pc = RESET_PC, if_insn = NOP_INSN, if_en = 0, fetch_cnt = 0, fetch_as_ = 1.
REQ-029 Reset asserted mid-hold or mid-branch SHALL override all other inputs in the same cycle; first fetch_addr after release is RESET_PC.

Configuration
REQ-030 Macro IFU_FETCH_CNT_EN defined: 32-bit counter fetch_cnt SHALL increment on every clock where if_en is loaded with 1 (branch or sequential), saturating at 32'hFFFFFFFF.
REQ-031 Macro IFU_FETCH_CNT_EN undefined: counter SHALL not be synthesized and fetch_cnt SHALL be tied to 32'h0.

Verification
REQ-032 Release reset with RESET_PC=0, insn=32'hA0000001: cycle 1 if_pc=0, if_insn=A0000001, if_en=1; fetch_addr steps 0,1,2,3.
REQ-033 fetch_pc=30'h10, assert stall 3 cycles: fetch_addr stays 10, if_* unchanged, fetch_cnt unchanged; release -> fetch_addr=11.
REQ-034 fetch_pc=30'h20, br_taken=1, br_addr=30'h100: next cycle if_pc=20, if_en=1, fetch_addr=100.
REQ-035 flush=1, new_pc=30'h40 with stall=1 and br_taken=1: next cycle fetch_addr=40, if_pc=40, if_insn=NOP_INSN, if_en=0.
REQ-036 fetch_pc=30'h3FFFFFFF, no hold: next fetch_addr=0, if_pc=3FFFFFFF; with IFU_FETCH_CNT_EN, 5 unheld fetches -> fetch_cnt=5; without it fetch_cnt=0.
